deser_shared2: RTL and testbench

- Flit deserializer shared by two packet formats. Gathers COUNT_0 or COUNT_1 consecutive SER_WIDTH-bit flits into one parallel word; count_sel picks the length.
- Sits at the NI response-path input, between the NoC link and the AXI B/R channel demux.
- Last flit passes straight through combinationally, so a packet is presented in the same cycle its final flit arrives.

---
 rtl/deser_shared2.sv | 90 +++++++++
 tb/tb_deser_shared2.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/deser_shared2.sv
// Flit deserializer shared by two packet formats: gathers COUNT_0 or COUNT_1 flits
// into one parallel word, with the final flit passed through combinationally.
module deser_shared2 #(
    parameter int SER_WIDTH = 128,
    parameter int COUNT_0   = 1,
    parameter int COUNT_1   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           count_sel,
    input  logic [SER_WIDTH-1:0]           serial_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [COUNT_0*SER_WIDTH-1:0]   parallel_out_0,
    output logic [COUNT_1*SER_WIDTH-1:0]   parallel_out_1,
    output logic                           valid_out,
    input  logic                           ready_in
);

    localparam int MAXC  = (COUNT_0 > COUNT_1) ? COUNT_0 : COUNT_1;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    // One dummy entry keeps the array legal when MAXC=1; it is never written then.
    localparam int DEPTH = (MAXC > 1) ? MAXC - 1 : 1;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SER_WIDTH-1:0] store_q [DEPTH];
    logic [CNT_W-1:0]     last_idx;
    logic                 last;
    logic                 store_we;

    assign last_idx = count_sel ? CNT_W'(COUNT_1 - 1) : CNT_W'(COUNT_0 - 1);
    assign last     = (cnt_q == last_idx);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d     = cnt_q;
        store_we  = 1'b0;
        ready_out = 1'b1;
        valid_out = 1'b0;
        if (last) begin
            valid_out = valid_in;
            ready_out = ready_in;
            if (valid_in && ready_in) begin
                cnt_d = '0;
            end
        end else if (valid_in) begin
            store_we = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the flit store is explicitly cleared on reset so a discarded partial
    // packet can never leak into a later output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                store_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (store_we && (cnt_q == CNT_W'(k))) begin
                    store_q[k] <= serial_in;
                end
            end
        end
    end

    // Stored flits fill the low slices; the top slice is always the live flit.
    for (genvar k = 0; k < COUNT_0 - 1; k++) begin : g_out0
        assign parallel_out_0[k*SER_WIDTH +: SER_WIDTH] = store_q[k];
    end
    assign parallel_out_0[(COUNT_0-1)*SER_WIDTH +: SER_WIDTH] = serial_in;

    for (genvar k = 0; k < COUNT_1 - 1; k++) begin : g_out1
        assign parallel_out_1[k*SER_WIDTH +: SER_WIDTH] = store_q[k];
    end
    assign parallel_out_1[(COUNT_1-1)*SER_WIDTH +: SER_WIDTH] = serial_in;

endmodule

// File: tb/tb_deser_shared2.sv
// Directed bench for deser_shared2 (SER_WIDTH=8, COUNT_0=1, COUNT_1=3) with a
// scoreboard of expected packets checked whenever the DUT presents a packet.
module tb_deser_shared2;

    localparam int W = 8;

    typedef struct {
        logic        sel;
        logic [23:0] data;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        count_sel;
    logic [W-1:0] serial_in;
    logic        valid_in;
    logic        ready_out;
    logic [W-1:0]   parallel_out_0;
    logic [3*W-1:0] parallel_out_1;
    logic        valid_out;
    logic        ready_in;

    pkt_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    deser_shared2 #(.SER_WIDTH(W), .COUNT_0(1), .COUNT_1(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .count_sel      (count_sel),
        .serial_in      (serial_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .parallel_out_0 (parallel_out_0),
        .parallel_out_1 (parallel_out_1),
        .valid_out      (valid_out),
        .ready_in       (ready_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sel, input logic [23:0] data);
        sb.push_back('{sel: sel, data: data});
    endtask

    // Drive one cycle of inputs, check handshake outputs at the falling edge, and
    // compare any presented packet with the scoreboard head (popped on transfer).
    task automatic step(input logic sel, input logic vin, input logic [W-1:0] din,
                        input logic rin, input logic exp_v, input logic exp_r,
                        input string tag);
        logic [23:0] obs;
        count_sel = sel;
        valid_in  = vin;
        serial_in = din;
        ready_in  = rin;
        @(negedge clk);
        check({tag, "_valid_out"}, 32'(valid_out), 32'(exp_v));
        check({tag, "_ready_out"}, 32'(ready_out), 32'(exp_r));
        if (valid_out === 1'b1) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL %s_sb: observed unexpected packet expected none", tag);
            end
            if (sb.size() != 0) begin
                obs = sb[0].sel ? parallel_out_1 : {16'h0, parallel_out_0};
                check({tag, "_data"}, 32'(obs), 32'(sb[0].data));
                if (ready_in) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        count_sel = 1'b1;
        valid_in  = 1'b0;
        serial_in = '0;
        ready_in  = 1'b0;

        // Reset state: format 1 is mid-packet-capable, format 0 is pass-through.
        #2;
        check("rst_sel1_ready_out", 32'(ready_out), 32'd1);
        check("rst_sel1_valid_out", 32'(valid_out), 32'd0);
        count_sel = 1'b0;
        #1;
        check("rst_sel0_ready_out", 32'(ready_out), 32'd0);
        ready_in = 1'b1;
        #1;
        check("rst_sel0_ready_follow", 32'(ready_out), 32'd1);

        // Test 1: single-flit pass-through right after reset release.
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(1'b0, 24'h0000A5);
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, "t1_pass");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t1_idle");

        // Test 2: three-flit packet.
        push(1'b1, 24'h332211);
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, "t2_f0");
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "t2_f1");
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, "t2_f2");

        // Test 3: backpressure on the last flit.
        push(1'b1, 24'h332211);
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, "t3_f0");
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "t3_f1");
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, "t3_stall0");
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, "t3_stall1");
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, "t3_accept");

        // Test 4: back-to-back mixed formats with no idle cycle.
        push(1'b1, 24'h030201);
        push(1'b0, 24'h000044);
        push(1'b1, 24'h070605);
        step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, "t4_a0");
        step(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, "t4_a1");
        step(1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, "t4_a2");
        step(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, "t4_b0");
        step(1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, "t4_c0");
        step(1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, "t4_c1");
        step(1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, "t4_c2");

        // Test 5: reset mid-packet discards the partial flit.
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, "t5_partial");
        valid_in = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(1'b1, 24'hCCBBAA);
        step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, "t5_f0");
        step(1'b1, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, "t5_f1");
        step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, "t5_f2");

        // Test 6: valid gaps between flits; counter advances only on valid cycles.
        push(1'b1, 24'h332211);
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, "t6_f0");
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, "t6_gap0");
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "t6_f1");
        step(1'b1, 1'b0, 8'hDD, 1'b1, 1'b0, 1'b1, "t6_gap1");
        step(1'b1, 1'b0, 8'hDD, 1'b1, 1'b0, 1'b1, "t6_gap2");
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, "t6_f2");

        // Counter must be back at 0: a format-0 flit passes straight through.
        push(1'b0, 24'h00005A);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, "t6_after");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
